bp_fe_ras_ctrl: RTL and testbench

// Return-address-stack controller for the FE; consumes per-fetch call/ret scan

---
 rtl/bp_fe_ras_ctrl.sv | 151 +++++++++++++++
 tb/tb_bp_fe_ras_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_ras_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bp_fe_ras_ctrl
// Brief    : Front-end return-address-stack controller. Circular stack with
//            saturating occupancy, {tos,count} checkpoints for speculation and
//            single-cycle pointer restore on back-end redirect.
// Options  : BP_FE_RAS_STATS_EN - adds saturating overflow/underflow counters
//            (overflow_cnt_o, underflow_cnt_o).
// Revision : 1.0 - initial release
// ============================================================================
module bp_fe_ras_ctrl #(
  parameter int ras_els_p     = 8,
  parameter int vaddr_width_p = 39,
  localparam int ptr_w        = $clog2(ras_els_p),
  localparam int cnt_w        = $clog2(ras_els_p + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic                     call_i,
  input  logic                     ret_i,
  input  logic [vaddr_width_p-1:0] pc_i,
  input  logic                     compressed_i,
  output logic [vaddr_width_p-1:0] ret_addr_o,
  output logic                     ret_v_o,
  output logic [ptr_w+cnt_w-1:0]   ckpt_o,
  input  logic                     restore_v_i,
  input  logic [ptr_w+cnt_w-1:0]   restore_ckpt_i
`ifdef BP_FE_RAS_STATS_EN
  ,
  output logic [15:0]              overflow_cnt_o,
  output logic [15:0]              underflow_cnt_o
`endif
);

  localparam logic [cnt_w-1:0] c_full_cnt = cnt_w'(ras_els_p);

  logic [vaddr_width_p-1:0] r_mem [ras_els_p];
  logic [ptr_w-1:0]         r_tos;
  logic [cnt_w-1:0]         r_count;

  logic                     w_op_en;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_swap;
  logic                     w_empty;
  logic                     w_full;
  logic [ptr_w-1:0]         w_tos_inc;
  logic [ptr_w-1:0]         w_tos_dec;
  logic [vaddr_width_p-1:0] w_link;
  logic                     w_we;
  logic [ptr_w-1:0]         w_waddr;
  logic [ptr_w-1:0]         w_rst_tos;
  logic [cnt_w-1:0]         w_rst_cnt_raw;
  logic [cnt_w-1:0]         w_rst_cnt;

  // A redirect overrides whatever the scanner reports in the same cycle.
  assign w_op_en   = v_i & ~restore_v_i;
  assign w_push    = w_op_en &  call_i & ~ret_i;
  assign w_pop     = w_op_en & ~call_i &  ret_i;
  assign w_swap    = w_op_en &  call_i &  ret_i;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == c_full_cnt);

  // Entry count is a power of two, so natural pointer overflow is the wrap.
  assign w_tos_inc = r_tos + ptr_w'(1);
  assign w_tos_dec = r_tos - ptr_w'(1);

  assign w_link    = pc_i + (compressed_i ? vaddr_width_p'(2) : vaddr_width_p'(4));

  // One write port: push writes above TOS, swap rewrites TOS in place.
  assign w_we      = w_push | w_swap;
  assign w_waddr   = w_push ? w_tos_inc : r_tos;

  // Checkpoint layout is {tos, count}; an out-of-range count is clamped.
  assign w_rst_tos     = restore_ckpt_i[ptr_w+cnt_w-1 -: ptr_w];
  assign w_rst_cnt_raw = restore_ckpt_i[cnt_w-1:0];
  assign w_rst_cnt     = (w_rst_cnt_raw > c_full_cnt) ? c_full_cnt : w_rst_cnt_raw;

  assign ret_addr_o = r_mem[r_tos];
  assign ret_v_o    = ~w_empty;
  assign ckpt_o     = {r_tos, r_count};

  // Stack pointer and saturating occupancy update.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_tos   <= '0;
      r_count <= '0;
    end else if (restore_v_i) begin
      r_tos   <= w_rst_tos;
      r_count <= w_rst_cnt;
    end else if (w_push) begin
      r_tos <= w_tos_inc;
      if (!w_full) begin
        r_count <= r_count + cnt_w'(1);
      end
    end else if (w_pop && !w_empty) begin
      r_tos   <= w_tos_dec;
      r_count <= r_count - cnt_w'(1);
    end else if (w_swap && w_empty) begin
      r_count <= cnt_w'(1);
    end
  end

  // Return-address storage; a full stack overwrites its oldest entry.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < ras_els_p; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_we) begin
      r_mem[w_waddr] <= w_link;
    end
  end

`ifndef SYNTHESIS
  // Flag illegal checkpoints handed back by the back end.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && restore_v_i) begin
      assert (w_rst_cnt_raw <= c_full_cnt)
        else $error("bp_fe_ras_ctrl: restored count %0d exceeds %0d", w_rst_cnt_raw, ras_els_p);
    end
  end
`endif

`ifdef BP_FE_RAS_STATS_EN
  logic [15:0] r_ovf_cnt;
  logic [15:0] r_unf_cnt;

  // Saturating event counters; redirects neither count nor clear them.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ovf_cnt <= '0;
      r_unf_cnt <= '0;
    end else begin
      if (w_push && w_full && (r_ovf_cnt != 16'hFFFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
      if (w_pop && w_empty && (r_unf_cnt != 16'hFFFF)) begin
        r_unf_cnt <= r_unf_cnt + 16'd1;
      end
    end
  end

  assign overflow_cnt_o  = r_ovf_cnt;
  assign underflow_cnt_o = r_unf_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_fe_ras_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_fe_ras_ctrl
// Brief    : Scoreboard bench for bp_fe_ras_ctrl. A driver applies directed and
//            random scan/redirect traffic and queues the expected outputs from
//            an array-based stack model; a monitor pops and compares.
// Options  : BP_FE_RAS_STATS_EN - also checks the event counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bp_fe_ras_ctrl;

  localparam int N  = 8;
  localparam int AW = 39;
  localparam int CW = 4;
  localparam int KW = 7;

  typedef struct {
    logic [AW-1:0] addr;
    logic          v;
    logic [KW-1:0] ckpt;
    logic [15:0]   ovf;
    logic [15:0]   unf;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          v_i;
  logic          call_i;
  logic          ret_i;
  logic [AW-1:0] pc_i;
  logic          compressed_i;
  logic [AW-1:0] ret_addr_o;
  logic          ret_v_o;
  logic [KW-1:0] ckpt_o;
  logic          restore_v_i;
  logic [KW-1:0] restore_ckpt_i;
`ifdef BP_FE_RAS_STATS_EN
  logic [15:0]   overflow_cnt_o;
  logic [15:0]   underflow_cnt_o;
`endif

  bp_fe_ras_ctrl #(.ras_els_p(N), .vaddr_width_p(AW)) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n_i),
    .v_i            (v_i),
    .call_i         (call_i),
    .ret_i          (ret_i),
    .pc_i           (pc_i),
    .compressed_i   (compressed_i),
    .ret_addr_o     (ret_addr_o),
    .ret_v_o        (ret_v_o),
    .ckpt_o         (ckpt_o),
    .restore_v_i    (restore_v_i),
    .restore_ckpt_i (restore_ckpt_i)
`ifdef BP_FE_RAS_STATS_EN
    ,
    .overflow_cnt_o (overflow_cnt_o),
    .underflow_cnt_o(underflow_cnt_o)
`endif
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Reference model: circular array, occupancy and event counts.
  logic [AW-1:0] m_mem [N];
  int            m_tos;
  int            m_cnt;
  int            m_ovf;
  int            m_unf;

  exp_t          exp_q[$];
  logic [KW-1:0] ck_hist[$];
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.addr = m_mem[m_tos];
    e.v    = (m_cnt != 0);
    e.ckpt = KW'(m_tos * 16 + m_cnt);
    e.ovf  = 16'(m_ovf);
    e.unf  = 16'(m_unf);
    return e;
  endfunction

  // Assert reset at a falling edge; the following step releases it.
  task automatic do_reset();
    @(negedge clk);
    reset_n_i      = 1'b0;
    v_i            = 1'b0;
    call_i         = 1'b0;
    ret_i          = 1'b0;
    pc_i           = '0;
    compressed_i   = 1'b0;
    restore_v_i    = 1'b0;
    restore_ckpt_i = '0;
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    m_tos = 0;
    m_cnt = 0;
    m_ovf = 0;
    m_unf = 0;
    exp_q.push_back(model_exp());
  endtask

  task automatic step(input logic v, input logic call, input logic ret,
                      input logic [AW-1:0] pc, input logic c,
                      input logic rv, input logic [KW-1:0] rck);
    logic [AW-1:0] link;
    longint        sum;
    @(negedge clk);
    reset_n_i      = 1'b1;
    v_i            = v;
    call_i         = call;
    ret_i          = ret;
    pc_i           = pc;
    compressed_i   = c;
    restore_v_i    = rv;
    restore_ckpt_i = rck;
    ck_hist.push_back(KW'(m_tos * 16 + m_cnt));
    if (ck_hist.size() > 16) void'(ck_hist.pop_front());
    sum  = longint'(pc) + (c ? 2 : 4);
    link = AW'(sum % (64'd1 << AW));
    if (rv) begin
      m_tos = int'(rck) / 16;
      m_cnt = int'(rck) % 16;
      if (m_cnt > N) m_cnt = N;
    end else if (v && call && !ret) begin
      if (m_cnt == N && m_ovf < 65535) m_ovf++;
      m_tos = (m_tos + 1) % N;
      m_mem[m_tos] = link;
      if (m_cnt < N) m_cnt++;
    end else if (v && ret && !call) begin
      if (m_cnt != 0) begin
        m_tos = (m_tos + N - 1) % N;
        m_cnt--;
      end else if (m_unf < 65535) begin
        m_unf++;
      end
    end else if (v && call && ret) begin
      m_mem[m_tos] = link;
      if (m_cnt == 0) m_cnt = 1;
    end
    exp_q.push_back(model_exp());
  endtask

  task automatic push_op(input logic [AW-1:0] pc, input logic c);
    step(1'b1, 1'b1, 1'b0, pc, c, 1'b0, '0);
  endtask

  task automatic pop_op();
    step(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic swap_op(input logic [AW-1:0] pc, input logic c);
    step(1'b1, 1'b1, 1'b1, pc, c, 1'b0, '0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expectation per clock edge, sampled just after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("ret_addr_o", 64'(ret_addr_o), 64'(e.addr));
      chk("ret_v_o", 64'(ret_v_o), 64'(e.v));
      chk("ckpt_o", 64'(ckpt_o), 64'(e.ckpt));
`ifdef BP_FE_RAS_STATS_EN
      chk("overflow_cnt_o", 64'(overflow_cnt_o), 64'(e.ovf));
      chk("underflow_cnt_o", 64'(underflow_cnt_o), 64'(e.unf));
`endif
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    logic [63:0]   rnd;
    int            sel;
    logic          rv;
    logic [KW-1:0] rck;

    reset_n_i = 1'b0;
    do_reset();

    // Reset in the middle of activity.
    push_op(39'h100, 1'b0);
    push_op(39'h200, 1'b0);
    push_op(39'h300, 1'b1);
    do_reset();
    settle();
    chk("mid_reset_ret_v", 64'(ret_v_o), 64'd0);
    chk("mid_reset_ret_addr", 64'(ret_addr_o), 64'd0);
    chk("mid_reset_ckpt", 64'(ckpt_o), 64'd0);

    // Basic push / pop / underflow.
    push_op(39'h1000, 1'b0);
    push_op(39'h2000, 1'b1);
    settle();
    chk("push2_addr", 64'(ret_addr_o), 64'h2002);
    pop_op();
    settle();
    chk("pop1_addr", 64'(ret_addr_o), 64'h1004);
    pop_op();
    settle();
    chk("pop2_ret_v", 64'(ret_v_o), 64'd0);
    pop_op();
    settle();
    chk("underflow_ret_v", 64'(ret_v_o), 64'd0);
    chk("underflow_ckpt", 64'(ckpt_o), 64'd0);
`ifdef BP_FE_RAS_STATS_EN
    chk("underflow_cnt", 64'(underflow_cnt_o), 64'd1);
`endif

    // Overflow with pointer wrap.
    do_reset();
    for (int i = 1; i <= 9; i++) push_op(AW'(i * 'h100), 1'b0);
    settle();
    chk("ovf_ckpt", 64'(ckpt_o), 64'h18);
    chk("ovf_addr", 64'(ret_addr_o), 64'h904);
    for (int i = 0; i < 8; i++) pop_op();
    settle();
    chk("ovf_drain_ret_v", 64'(ret_v_o), 64'd0);
`ifdef BP_FE_RAS_STATS_EN
    chk("overflow_cnt", 64'(overflow_cnt_o), 64'd1);
`endif

    // Checkpoint restore beats a same-cycle push.
    do_reset();
    push_op(39'hA000, 1'b0);
    push_op(39'hB000, 1'b0);
    settle();
    chk("save_ckpt", 64'(ckpt_o), 64'h22);
    push_op(39'hC000, 1'b0);
    push_op(39'hD000, 1'b0);
    push_op(39'hE000, 1'b0);
    pop_op();
    step(1'b1, 1'b1, 1'b0, 39'hF000, 1'b0, 1'b1, 7'h22);
    settle();
    chk("restore_addr", 64'(ret_addr_o), 64'hB004);
    chk("restore_ckpt", 64'(ckpt_o), 64'h22);

    // Coroutine swap.
    do_reset();
    swap_op(39'h3000, 1'b1);
    settle();
    chk("swap_empty_ckpt", 64'(ckpt_o), 64'h01);
    chk("swap_empty_addr", 64'(ret_addr_o), 64'h3002);
    push_op(39'h5000, 1'b0);
    swap_op(39'h4000, 1'b0);
    settle();
    chk("swap_full_ckpt", 64'(ckpt_o), 64'h12);
    chk("swap_full_addr", 64'(ret_addr_o), 64'h4004);

    // Link address wraps at the top of the address space.
    do_reset();
    push_op(39'h7F_FFFF_FFFE, 1'b1);
    settle();
    chk("wrap_addr", 64'(ret_addr_o), 64'd0);
    chk("wrap_ret_v", 64'(ret_v_o), 64'd1);

    // Randomized traffic with redirects and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        rnd = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) rnd[AW-1:3] = '1;
        sel = $urandom_range(0, 9);
        rv  = (sel == 0);
        rck = ck_hist[$urandom_range(0, ck_hist.size() - 1)];
        step($urandom_range(0, 4) != 0, 1'($urandom), 1'($urandom),
             AW'(rnd), 1'($urandom), rv, rck);
      end
    end

    settle();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
